clk_phase_monitor: RTL and testbench



---
 rtl/clk_phase_monitor_pkg.sv | 17 +
 rtl/clk_phase_monitor_edge_detect.sv | 71 +++++++
 rtl/clk_phase_monitor.sv | 152 +++++++++++++++
 tb/tb_clk_phase_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_phase_monitor_pkg.sv
// Shared definitions for the divided-clock phase monitor.
//
// Holds the monitor FSM state encoding and the default width of the
// half-period counter. Imported by clk_phase_monitor.
package clk_phase_monitor_pkg;

  // Default width of the half-period counter and of half_len.
  localparam int unsigned CntWDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcq   = 2'd1,
    StLock  = 2'd2,
    StFault = 2'd3
  } clkmon_state_e;

endpackage

// File: rtl/clk_phase_monitor_edge_detect.sv
// Edge detector for a slow clock treated as data.
//
// Samples din on every posedge of clk and reports level changes. The
// toggle output is combinational: it is high during the cycle whose
// closing posedge will register the new level. rise/fall are registered
// and high for exactly one cycle after that posedge.
//
// Configuration macro: CLKMON_SYNC_EN inserts a 2-flop synchronizer
// (reset to INIT_LVL) ahead of the sampling register, adding 2 cycles of
// latency to every output.
//
// Ports:
//   clk    in   fast sampling clock
//   rst    in   synchronous active-high reset
//   din    in   monitored signal
//   level  out  sampled level of din
//   toggle out  level change will be taken at the next posedge
//   rise   out  one-cycle strobe on a 0->1 change
//   fall   out  one-cycle strobe on a 1->0 change
module clk_phase_monitor_edge_detect #(
  parameter bit INIT_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic toggle,
  output logic rise,
  output logic fall
);

  logic in_s;
  logic samp_q;
  logic rise_q;
  logic fall_q;

`ifdef CLKMON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{INIT_LVL}};
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign in_s = sync_q[1];
`else
  assign in_s = din;
`endif

  assign toggle = (in_s != samp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= INIT_LVL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      samp_q <= in_s;
      rise_q <= toggle & in_s;
      fall_q <= toggle & ~in_s;
    end
  end

  assign level = samp_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/clk_phase_monitor.sv
// Divided-clock phase monitor.
//
// Treats a divided clock as data in the fast clk domain: emits rise/fall
// strobes, measures every half-period and tracks lock. Lock is declared
// after LOCK_CNT consecutive in-tolerance half-periods; losing it (bad
// half-period or stuck level) raises a sticky fault cleared by clr_fault.
//
// Configuration macro: CLKMON_SYNC_EN (see clk_phase_monitor_edge_detect)
// adds a 2-flop synchronizer on clk_in; measured half periods are unchanged.
//
// Ports:
//   clk       in   fast system clock
//   rst       in   synchronous active-high reset
//   clk_in    in   monitored divided clock
//   clr_fault in   pulse; leaves the fault state
//   rise      out  one-cycle strobe on 0->1 of clk_in
//   fall      out  one-cycle strobe on 1->0 of clk_in
//   phase     out  sampled level of clk_in
//   half_len  out  length of the last completed half-period, in clk cycles
//   locked    out  monitor is locked
//   fault     out  sticky fault flag
module clk_phase_monitor
  import clk_phase_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned EXP_HALF = 1,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4,
  parameter bit          INIT_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             clr_fault,
  output logic             rise,
  output logic             fall,
  output logic             phase,
  output logic [CNT_W-1:0] half_len,
  output logic             locked,
  output logic             fault
);

  // Tolerance window, one bit wider than the counter so cnt+1 never wraps.
  localparam int unsigned   LoBound = (TOL >= EXP_HALF) ? 1 : (EXP_HALF - TOL);
  localparam int unsigned   HiBound = EXP_HALF + TOL;
  localparam logic [CNT_W:0] Lo     = (CNT_W + 1)'(LoBound);
  localparam logic [CNT_W:0] Hi     = (CNT_W + 1)'(HiBound);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic toggle;

  clk_phase_monitor_edge_detect #(
    .INIT_LVL (INIT_LVL)
  ) u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .din    (clk_in),
    .level  (phase),
    .toggle (toggle),
    .rise   (rise),
    .fall   (fall)
  );

  clkmon_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_len_q, half_len_d;
  logic [3:0]       good_q, good_d;

  logic [CNT_W:0]   meas;
  logic [CNT_W-1:0] meas_sat;
  logic [4:0]       good_inc;
  logic             in_tol;
  logic             timeout;

  // Length of the current half-period if it ended at this posedge.
  assign meas     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign meas_sat = meas[CNT_W] ? CntMax : meas[CNT_W-1:0];
  assign in_tol   = (meas >= Lo) && (meas <= Hi);
  // The half-period has reached the maximum and still has not ended.
  assign timeout  = !toggle && (meas == Hi);
  assign good_inc = {1'b0, good_q} + 5'd1;

  always_comb begin
    cnt_d      = cnt_q;
    half_len_d = half_len_q;
    if (toggle) begin
      cnt_d      = '0;
      half_len_d = meas_sat;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      StIdle: begin
        // The first half-period has an unknown start, so it is not judged.
        if (toggle) begin
          state_d = StAcq;
          good_d  = '0;
        end
      end
      StAcq: begin
        if (toggle) begin
          if (!in_tol) begin
            good_d = '0;
          end else if (good_inc == 5'(LOCK_CNT)) begin
            state_d = StLock;
            good_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StLock: begin
        if ((toggle && !in_tol) || timeout) begin
          state_d = StFault;
        end
      end
      StFault: begin
        // Any edge in this cycle is still measured but does not move the FSM.
        if (clr_fault) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_len_q <= '0;
      good_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_len_q <= half_len_d;
      good_q     <= good_d;
    end
  end

  assign half_len = half_len_q;
  assign locked   = (state_q == StLock);
  assign fault    = (state_q == StFault);

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Bench for clk_phase_monitor: three instances (defaults, EXP_HALF=4/TOL=1,
// INIT_LVL=1). Every driven level change pushes the expected strobe,
// half_len and arrival cycle into a scoreboard; a negedge monitor pops and
// compares whenever any instance strobes.
module tb_clk_phase_monitor;

  localparam int W = 8;
`ifdef CLKMON_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   clkin;
  logic [2:0]   clr;
  logic [2:0]   rise_v, fall_v, phase_v, locked_v, fault_v;
  logic [W-1:0] hl [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  clk_phase_monitor u_dflt (
    .clk (clk), .rst (rst), .clk_in (clkin[0]), .clr_fault (clr[0]),
    .rise (rise_v[0]), .fall (fall_v[0]), .phase (phase_v[0]),
    .half_len (hl[0]), .locked (locked_v[0]), .fault (fault_v[0])
  );

  clk_phase_monitor #(.EXP_HALF (4), .TOL (1)) u_tol (
    .clk (clk), .rst (rst), .clk_in (clkin[1]), .clr_fault (clr[1]),
    .rise (rise_v[1]), .fall (fall_v[1]), .phase (phase_v[1]),
    .half_len (hl[1]), .locked (locked_v[1]), .fault (fault_v[1])
  );

  clk_phase_monitor #(.INIT_LVL (1'b1)) u_inv (
    .clk (clk), .rst (rst), .clk_in (clkin[2]), .clr_fault (clr[2]),
    .rise (rise_v[2]), .fall (fall_v[2]), .phase (phase_v[2]),
    .half_len (hl[2]), .locked (locked_v[2]), .fault (fault_v[2])
  );

  typedef struct {
    int inst;
    bit up;
    int hl;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  bit   init_lvl  [3] = '{1'b0, 1'b0, 1'b1};
  bit   model_lvl [3];
  int   model_run [3];

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Called at a negedge: drive level for n posedges, predicting any strobe.
  task automatic hold(input int i, input bit lvl, input int n);
    clkin[i] = lvl;
    if (lvl != model_lvl[i]) begin
      sb_q.push_back('{inst: i, up: lvl, hl: model_run[i] + 1, due: cyc + 1 + SX});
      model_run[i] = 0;
      model_lvl[i] = lvl;
    end else begin
      model_run[i]++;
    end
    model_run[i] += n - 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle(input int i, input int k);
    for (int j = 0; j < k; j++) hold(i, !model_lvl[i], 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = '0;
    for (int k = 0; k < 3; k++) begin
      clkin[0] = ~clkin[0];
      clkin[1] = ~clkin[1];
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_rise",     int'(rise_v[i]),   0);
      check_eq("rst_fall",     int'(fall_v[i]),   0);
      check_eq("rst_phase",    int'(phase_v[i]),  int'(init_lvl[i]));
      check_eq("rst_half_len", int'(hl[i]),       0);
      check_eq("rst_locked",   int'(locked_v[i]), 0);
      check_eq("rst_fault",    int'(fault_v[i]),  0);
    end
    check_eq("sb_drained_before_rst", sb_q.size(), 0);
    clkin = 3'b100;
    rst   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_lvl[i] = init_lvl[i];
      model_run[i] = SX;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (rise_v[i] || fall_v[i]) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_strobe", int'(rise_v[i] | fall_v[i]), 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("sb_inst",     i,               e.inst);
            check_eq("sb_rise",     int'(rise_v[i]), int'(e.up));
            check_eq("sb_fall",     int'(fall_v[i]), int'(!e.up));
            check_eq("sb_phase",    int'(phase_v[i]), int'(e.up));
            check_eq("sb_half_len", int'(hl[i]),     e.hl);
            check_eq("sb_latency",  cyc,             e.due);
          end
        end
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        check_eq("sb_missing_strobe", cyc, sb_q[0].due);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit l;
    clkin = 3'b100;
    clr   = '0;
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    // Divide-by-2 source on the default instance.
    hold(0, 1'b0, 1);
    check_eq("post_rst_rise", int'(rise_v[0]), 0);
    check_eq("post_rst_fall", int'(fall_v[0]), 0);
    toggle(0, 4 + SX);
    check_eq("div2_not_yet_locked", int'(locked_v[0]), 0);
    toggle(0, 1);
    check_eq("div2_locked", int'(locked_v[0]), 1);
    check_eq("div2_no_fault", int'(fault_v[0]), 0);
    clr[0] = 1'b1;
    toggle(0, 1);
    clr[0] = 1'b0;
    toggle(0, 4);
    check_eq("clr_ignored_locked", int'(locked_v[0]), 1);
    check_eq("clr_ignored_fault", int'(fault_v[0]), 0);

    // Stuck divider while locked.
    if (SX > 0) hold(0, model_lvl[0], SX);
    check_eq("stuck_still_locked", int'(locked_v[0]), 1);
    check_eq("stuck_no_fault_yet", int'(fault_v[0]), 0);
    hold(0, model_lvl[0], 1);
    check_eq("stuck_fault", int'(fault_v[0]), 1);
    check_eq("stuck_unlocked", int'(locked_v[0]), 0);
    hold(0, model_lvl[0], 3);
    check_eq("fault_sticky", int'(fault_v[0]), 1);
    clr[0] = 1'b1;
    hold(0, model_lvl[0], 1);
    clr[0] = 1'b0;
    check_eq("stuck_clr_fault", int'(fault_v[0]), 0);
    check_eq("stuck_clr_locked", int'(locked_v[0]), 0);

    // Reacquisition: half-periods 1,1,3 then four of 1.
    l = model_lvl[0];
    hold(0, !l, 1);
    hold(0, l, 1);
    hold(0, !l, 3);
    hold(0, l, 1);
    toggle(0, 3 + SX);
    check_eq("reacq_good_reset", int'(locked_v[0]), 0);
    toggle(0, 1);
    check_eq("reacq_locked", int'(locked_v[0]), 1);
    hold(0, model_lvl[0], 4);

    // Tolerance window 3..5 on the EXP_HALF=4/TOL=1 instance.
    do_reset();
    hold(1, 1'b1, 4);
    hold(1, 1'b0, 5);
    hold(1, 1'b1, 3);
    hold(1, 1'b0, 4);
    check_eq("tol_acq_unlocked", int'(locked_v[1]), 0);
    hold(1, 1'b1, 4);
    check_eq("tol_locked", int'(locked_v[1]), 1);
    hold(1, 1'b0, 5 + SX);
    check_eq("tol_prefault_locked", int'(locked_v[1]), 1);
    check_eq("tol_prefault_fault", int'(fault_v[1]), 0);
    hold(1, 1'b0, 1);
    check_eq("tol_long_half_fault", int'(fault_v[1]), 1);
    check_eq("tol_long_half_unlocked", int'(locked_v[1]), 0);
    clr[1] = 1'b1;
    hold(1, 1'b0, 1);
    clr[1] = 1'b0;
    check_eq("tol_clr_fault", int'(fault_v[1]), 0);
    hold(1, 1'b0, 4);

    // Inverted initial level: only a fall strobe is expected.
    do_reset();
    hold(2, 1'b1, 4);
    hold(2, 1'b0, 6);
    check_eq("inv_phase_low", int'(phase_v[2]), 0);
    check_eq("inv_no_fault", int'(fault_v[2]), 0);
    check_eq("sb_drained_end", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
